// File: rtl/lfsr_match_collector_if.sv
// Link between the match collector and the LFSR generator / host readout.
// master = collector side, slave = generator plus host reader side.
interface lfsr_match_collector_if #(
    parameter int N     = 64,
    parameter int CNT_W = 32
);
    logic             gen_start;
    logic             gen_pause;
    logic             gen_reset_counter;
    logic [N-1:0]     gen_data;
    logic             gen_valid;
    logic             gen_done;
    logic             match_valid;
    logic [N-1:0]     match_data;
    logic [CNT_W-1:0] match_index;
    logic             match_rd;

    modport master (
        output gen_start,
        output gen_pause,
        output gen_reset_counter,
        input  gen_data,
        input  gen_valid,
        input  gen_done,
        output match_valid,
        output match_data,
        output match_index,
        input  match_rd
    );

    modport slave (
        input  gen_start,
        input  gen_pause,
        input  gen_reset_counter,
        output gen_data,
        output gen_valid,
        output gen_done,
        input  match_valid,
        input  match_data,
        input  match_index,
        output match_rd
    );
endinterface

// File: rtl/lfsr_match_collector.sv
// Drives the LFSR generator, matches its stream against a masked target
// and queues hits with their stream index in a small FWFT FIFO.
module lfsr_match_collector #(
    parameter int N     = 64,
    parameter int CNT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [N-1:0]         target,
    input  logic [N-1:0]         mask,
    lfsr_match_collector_if.master bus,
    output logic [CNT_W-1:0]     word_count,
    output logic                 busy,
    output logic                 finished,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PAUSE_AT = DEPTH - 2;
    localparam logic [AW:0] OCC_FULL = DEPTH[AW:0];
    localparam logic [AW:0] OCC_PAUSE = PAUSE_AT[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RUN,
        ABORT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]     mem_data [DEPTH];
    logic [CNT_W-1:0] mem_idx  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic in_run;
    logic flush;
    logic accept;
    logic hit;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (go) state_nxt = CLEAR;
            CLEAR:   state_nxt = START;
            START:   state_nxt = RUN;
            RUN: begin
                if (abort)             state_nxt = ABORT;
                else if (bus.gen_done) state_nxt = DONE;
            end
            ABORT:   state_nxt = IDLE;
            DONE: begin
                if (abort)   state_nxt = ABORT;
                else if (go) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_run = (state == RUN);
    assign flush  = (state == CLEAR);

    assign busy     = (state == CLEAR) || (state == START) || in_run;
    assign finished = (state == DONE);

    assign bus.gen_start = (state == START);
    assign bus.gen_reset_counter = flush || (state == ABORT);
    // Pause only in RUN so the ABORT/CLEAR counter reset is never masked.
    assign bus.gen_pause = in_run && (occ >= OCC_PAUSE);

    assign accept = in_run && bus.gen_valid;
    assign hit = accept && (((bus.gen_data ^ target) & mask) == '0);

    assign empty = (occ == '0);
    assign full  = (occ == OCC_FULL);
    assign pop   = bus.match_rd && !empty;
    assign push  = hit && (!full || pop);
    assign drop  = hit && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
            if (drop) overflow <= 1'b1;
            if (accept && (word_count != '1)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.gen_data;
            mem_idx[wr_ptr]  <= word_count;
        end
    end

    // Head is zeroed when empty so reset leaves every output at 0.
    assign bus.match_valid = !empty;
    assign bus.match_data  = empty ? '0 : mem_data[rd_ptr];
    assign bus.match_index = empty ? '0 : mem_idx[rd_ptr];
endmodule

// File: tb/tb_lfsr_match_collector.sv
// Directed-plus-random bench for lfsr_match_collector with a queue-level
// reference model and a behavioural generator.
module tb_lfsr_match_collector;
    localparam int N = 64;
    localparam int CW = 32;
    localparam int DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_START = 2;
    localparam int M_RUN   = 3;
    localparam int M_ABORT = 4;
    localparam int M_DONE  = 5;

    typedef struct {
        logic [N-1:0]  d;
        logic [CW-1:0] i;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  target = '0;
    logic [N-1:0]  mask = '0;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          finished;
    logic          overflow;

    lfsr_match_collector_if #(.N(N), .CNT_W(CW)) bus ();

    lfsr_match_collector #(.N(N), .CNT_W(CW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .abort(abort),
        .target(target),
        .mask(mask),
        .bus(bus),
        .word_count(word_count),
        .busy(busy),
        .finished(finished),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            ms = M_IDLE;
    ent_t          q[$];
    logic [CW-1:0] cnt = '0;
    bit            ovf = 0;

    logic [N-1:0]  words[$];
    int            gpos = 0;
    bit            gen_on = 0;
    bit            ignore_pause = 0;
    logic [CW-1:0] pops[$];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = M_IDLE;
        q.delete();
        cnt = '0;
        ovf = 0;
    endtask

    task automatic model_edge();
        bit acc;
        bit hit;
        bit pop;
        int nxt;
        if (rst) begin
            model_reset();
            return;
        end
        acc = (ms == M_RUN) && bus.gen_valid;
        hit = acc && (((bus.gen_data ^ target) & mask) == '0);
        pop = bus.match_rd && (q.size() != 0);
        if (ms == M_CLEAR) begin
            q.delete();
            cnt = '0;
            ovf = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (hit) begin
                if (q.size() < DEPTH) q.push_back('{bus.gen_data, cnt});
                else ovf = 1;
            end
            if (acc && cnt != '1) cnt = cnt + 1;
        end
        nxt = ms;
        case (ms)
            M_IDLE:  if (go) nxt = M_CLEAR;
            M_CLEAR: nxt = M_START;
            M_START: nxt = M_RUN;
            M_RUN: begin
                if (abort)             nxt = M_ABORT;
                else if (bus.gen_done) nxt = M_DONE;
            end
            M_ABORT: nxt = M_IDLE;
            M_DONE: begin
                if (abort)   nxt = M_ABORT;
                else if (go) nxt = M_CLEAR;
            end
            default: nxt = M_IDLE;
        endcase
        ms = nxt;
    endtask

    task automatic check_all();
        bit ne;
        ne = (q.size() != 0);
        chk("match_valid", bus.match_valid, ne);
        if (ne) begin
            chk("match_data", bus.match_data, q[0].d);
            chk("match_index", bus.match_index, q[0].i);
        end
        chk("word_count", word_count, cnt);
        chk("overflow", overflow, ovf);
        chk("busy", busy,
            ms == M_CLEAR || ms == M_START || ms == M_RUN);
        chk("finished", finished, ms == M_DONE);
        chk("gen_start", bus.gen_start, ms == M_START);
        chk("gen_reset_counter", bus.gen_reset_counter,
            ms == M_CLEAR || ms == M_ABORT);
        chk("gen_pause", bus.gen_pause,
            ms == M_RUN && q.size() >= DEPTH - 2);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_match_valid"}, bus.match_valid, 0);
        chk({tag, "_match_data"}, bus.match_data, 0);
        chk({tag, "_match_index"}, bus.match_index, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_gen_start"}, bus.gen_start, 0);
        chk({tag, "_gen_pause"}, bus.gen_pause, 0);
        chk({tag, "_gen_rc"}, bus.gen_reset_counter, 0);
    endtask

    // Registered generator: next valid is decided from pause seen before the edge.
    task automatic gen_update(bit p, bit s, bit rc, bit v);
        bus.gen_done = 1'b0;
        if (rc) begin
            gen_on = 0;
            bus.gen_valid = 1'b0;
        end else if (s) begin
            gen_on = 1;
            gpos = 0;
            bus.gen_valid = 1'b1;
            bus.gen_data = words[0];
        end else if (gen_on) begin
            if (v) gpos++;
            if (gpos >= words.size()) begin
                gen_on = 0;
                bus.gen_valid = 1'b0;
                bus.gen_done = 1'b1;
            end else begin
                bus.gen_valid = ignore_pause || !p;
                bus.gen_data = words[gpos];
            end
        end
    endtask

    task automatic step();
        bit p;
        bit s;
        bit rc;
        bit v;
        if (bus.match_valid && bus.match_rd) pops.push_back(bus.match_index);
        model_edge();
        p  = bus.gen_pause;
        s  = bus.gen_start;
        rc = bus.gen_reset_counter;
        v  = bus.gen_valid;
        @(posedge clk);
        #1;
        go = 1'b0;
        abort = 1'b0;
        gen_update(p, s, rc, v);
        check_all();
    endtask

    task automatic make_words(int len, logic [N-1:0] seed);
        logic [N-1:0] w;
        words.delete();
        words.push_back(seed);
        for (int k = 0; k < len - 2; k++) begin
            w = {$urandom, $urandom};
            if (w == seed) w = ~seed;
            words.push_back(w);
        end
        words.push_back(seed);
    endtask

    task automatic run_to_done(string tag, int budget);
        for (int k = 0; k < budget; k++) begin
            if (ms == M_DONE) break;
            step();
        end
        chk(tag, finished, 1);
    endtask

    task automatic wait_pause(string tag, int budget);
        for (int k = 0; k < budget; k++) begin
            if (bus.gen_pause) break;
            step();
        end
        chk(tag, bus.gen_pause, 1);
    endtask

    initial begin
        logic [N-1:0] seed;
        bus.gen_data = '0;
        bus.gen_valid = 1'b0;
        bus.gen_done = 1'b0;
        bus.match_rd = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Run 1: every word matches, reader always ready.
        seed = {$urandom, $urandom};
        make_words(5, seed);
        mask = '0;
        target = {$urandom, $urandom};
        bus.match_rd = 1'b1;
        pops.delete();
        go = 1'b1;
        step();
        run_to_done("run1_done", 40);
        step();
        chk("run1_word_count", word_count, 5);
        chk("run1_overflow", overflow, 0);
        chk("run1_pop_count", pops.size(), 5);
        foreach (pops[k]) chk("run1_pop_index", pops[k], k);

        // Run 2: exact compare against the seed word.
        seed = {$urandom, $urandom};
        make_words(5, seed);
        mask = '1;
        target = seed;
        pops.delete();
        go = 1'b1;
        step();
        run_to_done("run2_done", 40);
        step();
        chk("run2_pop_count", pops.size(), 2);
        if (pops.size() == 2) begin
            chk("run2_first_index", pops[0], 0);
            chk("run2_second_index", pops[1], 4);
        end

        // Run 3: backpressure with reader stalled, then resume.
        make_words(12, {$urandom, $urandom});
        mask = '0;
        bus.match_rd = 1'b0;
        go = 1'b1;
        step();
        wait_pause("run3_pause_rose", 20);
        repeat (3) step();
        chk("run3_no_overflow", overflow, 0);
        bus.match_rd = 1'b1;
        repeat (2) step();
        bus.match_rd = 1'b0;
        chk("run3_pause_dropped", bus.gen_pause, 0);
        step();
        bus.match_rd = 1'b1;
        run_to_done("run3_done", 80);
        chk("run3_word_count", word_count, 12);
        bus.match_rd = 1'b0;

        // Run 4: generator ignores pause, FIFO overflows.
        make_words(5, {$urandom, $urandom});
        ignore_pause = 1;
        go = 1'b1;
        step();
        run_to_done("run4_done", 40);
        chk("run4_overflow", overflow, 1);
        chk("run4_fifo_full", bus.match_valid, 1);
        ignore_pause = 0;

        // Run 5: go clears overflow, then abort while paused.
        make_words(20, {$urandom, $urandom});
        go = 1'b1;
        step();
        step();
        chk("run5_overflow_cleared", overflow, 0);
        chk("run5_fifo_flushed", bus.match_valid, 0);
        wait_pause("run5_pause_rose", 20);
        repeat (2) step();
        abort = 1'b1;
        step();
        chk("abort_rc", bus.gen_reset_counter, 1);
        chk("abort_pause", bus.gen_pause, 0);
        step();
        chk("abort_idle_busy", busy, 0);
        chk("abort_fifo_kept", bus.match_valid, 1);
        bus.match_rd = 1'b1;
        repeat (5) step();
        chk("abort_drained", bus.match_valid, 0);

        // Run 6: asynchronous reset in the middle of a run.
        make_words(20, {$urandom, $urandom});
        go = 1'b1;
        step();
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        gen_on = 0;
        bus.gen_valid = 1'b0;
        bus.match_rd = 1'b0;
        check_zero("async_rst");
        #2;
        rst = 1'b0;
        repeat (2) step();
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
